// File: rtl/tc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tc_ctrl_pkg
// Shared types and constants for the systolic tile sequencer.
//   tc_state_e : sequencer states, in the order a tile walks through them.
//   TC_N       : default array dimension (rows = cols).
//   DRAIN_CYC  : cycles spent draining the skewed array after the last input
//                vector (2 * TC_N). An instance with a different N scales it.
// ----------------------------------------------------------------------------
package tc_ctrl_pkg;

    localparam int TC_N      = 4;
    localparam int DRAIN_CYC = 2 * TC_N;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SWITCH = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } tc_state_e;

endpackage

// File: rtl/valid_skew_pipe.sv
// ----------------------------------------------------------------------------
// valid_skew_pipe
// Delay chain that skews one valid bit across the N rows of the array:
// taps[i] is src delayed by i cycles (taps[0] is src itself). Every tap
// carries the same input, so one shift register tapped at each stage is
// enough.
// Ports:
//   clk   in   1   clock
//   rst   in   1   synchronous active-low reset
//   clr   in   1   synchronous clear (tile aborted)
//   src   in   1   valid bit entering row 0
//   taps  out  N   per-row skewed valid
// ----------------------------------------------------------------------------
module valid_skew_pipe #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         src,
    output logic [N-1:0] taps
);

    if (N == 1) begin : g_single
        assign taps = src;
    end else begin : g_chain
        logic [N-2:0] chain;

        // NOTE: every stage is cleared, not just the head; a stale 1 left in
        // the chain after an abort would fire a PE row during the next tile.
        always_ff @(posedge clk) begin
            if (!rst || clr) begin
                chain <= '0;
            end else begin
                chain[0] <= src;
                for (int k = 1; k < N - 1; k++) begin
                    chain[k] <= chain[k-1];
                end
            end
        end

        assign taps = {chain, src};
    end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// ----------------------------------------------------------------------------
// systolic_tile_ctrl
// Sequencer for one N x N weight-stationary PE array. Each accepted start runs
// one tile: preload N weight rows (bottom row first), pulse switch, stream V
// input vectors with per-row skewed valid, drain the array, pulse done.
// Drives buffer read ports and array control only; no datapath.
//
// Optional feature: define TC_PERF_CNT_EN to add the perf_cycles port, a
// saturating count of busy cycles in the most recent tile.
//
// Ports:
//   clk           in   1          clock
//   rst           in   1          synchronous active-low reset
//   start         in   1          tile request, sampled only in IDLE
//   abort         in   1          cancel current tile (no done pulse)
//   cfg_num_vec   in   VEC_W      vector count V, latched with start
//   busy          out  1          high in every state except IDLE
//   done          out  1          one-cycle pulse on tile completion
//   w_rd_en       out  1          weight buffer read strobe
//   w_rd_addr     out  clog2(N)   weight row address, N-1 down to 0
//   arr_accept_w  out  1          weight accept into the array (w_rd_en + 1)
//   arr_switch    out  1          one-cycle weight switch pulse
//   in_rd_en      out  1          input buffer read strobe
//   in_rd_addr    out  VEC_W      input vector address, 0 to V-1
//   arr_valid     out  N          per-row skewed input valid
//   perf_cycles   out  32         busy-cycle count (TC_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module systolic_tile_ctrl
    import tc_ctrl_pkg::*;
#(
    parameter int N     = TC_N,
    parameter int VEC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [VEC_W-1:0]     cfg_num_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic [$clog2(N)-1:0] w_rd_addr,
    output logic                 arr_accept_w,
    output logic                 arr_switch,
    output logic                 in_rd_en,
    output logic [VEC_W-1:0]     in_rd_addr,
    output logic [N-1:0]         arr_valid
`ifdef TC_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam int AW        = $clog2(N);
    localparam int LCW       = AW + 1;                    // counts 0..N
    localparam int DRAIN_LEN = DRAIN_CYC / TC_N * N;      // 2*N for this instance
    localparam int DCW       = $clog2(DRAIN_LEN);

    tc_state_e        state;
    tc_state_e        state_nxt;
    logic [LCW-1:0]   load_cnt;
    logic [VEC_W-1:0] str_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic [VEC_W-1:0] v_reg;
    logic             accept_q;
    logic             vld_q;
    logic             abort_hit;

    // abort is meaningless in IDLE, so a simultaneous start still wins there.
    assign abort_hit = abort && (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        done         = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        arr_switch   = 1'b0;
        in_rd_en     = 1'b0;
        in_rd_addr   = '0;

        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                // N read cycles, then one extra cycle so the last accept_w
                // lands before the switch pulse.
                if (load_cnt < LCW'(N)) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = AW'(N - 1) - load_cnt[AW-1:0];
                end else begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                arr_switch = 1'b1;
                state_nxt  = (v_reg == '0) ? DONE : STREAM;
            end
            STREAM: begin
                in_rd_en   = 1'b1;
                in_rd_addr = str_cnt;
                if (str_cnt == v_reg - VEC_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DCW'(DRAIN_LEN - 1)) state_nxt = DONE;
            end
            DONE: begin
                // An abort arriving in the completion cycle suppresses done.
                done      = !abort;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort_hit) state_nxt = IDLE;
    end

    // Phase counters restart from zero whenever their phase is not active,
    // so each phase begins counting at 0 without an explicit load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_cnt  <= '0;
            str_cnt   <= '0;
            drain_cnt <= '0;
            v_reg     <= '0;
            accept_q  <= 1'b0;
            vld_q     <= 1'b0;
        end else if (abort_hit) begin
            load_cnt  <= '0;
            str_cnt   <= '0;
            drain_cnt <= '0;
            accept_q  <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            accept_q  <= w_rd_en;   // buffer read latency is one cycle
            vld_q     <= in_rd_en;
            if (state == IDLE && start) v_reg <= cfg_num_vec;
            load_cnt  <= (state == LOAD)   ? load_cnt + LCW'(1)   : '0;
            str_cnt   <= (state == STREAM) ? str_cnt + VEC_W'(1)  : '0;
            drain_cnt <= (state == DRAIN)  ? drain_cnt + DCW'(1)  : '0;
        end
    end

    assign arr_accept_w = accept_q;

    valid_skew_pipe #(
        .N (N)
    ) u_skew (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort_hit),
        .src  (vld_q),
        .taps (arr_valid)
    );

`ifdef TC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
